rv32i_fetch: RTL and testbench
==============================

Name: rv32i_fetch

Overview:
Instruction fetch unit that drives the decoder's instr/pc_in inputs. It issues pipelined word reads to instruction memory over an Avalon-MM-style read interface and buffers the returned words in a small prefetch FIFO. It presents one instruction per cycle to the decoder, or a NOP bubble when none is available. On a PC update from the ALU it flushes all state, and it discards any read responses still in flight for the old path.

Parameters:
RV32I_RESET_VECTOR, 32'h00000000, first fetch address after reset
RV32I_FETCH_DEPTH, 4, prefetch FIFO entries; power of two, 2..16; also the maximum of outstanding reads plus FIFO occupancy

Ports:
clk  input  1  system clock
reset_n  input  1  reset
iaddr  output  32  instruction memory word address (bits [1:0] always 0)
iread  output  1  read request
iwaitrequest  input  1  memory not accepting; hold iread/iaddr
ireaddata  input  32  read data
ireaddatavalid  input  1  read data valid; responses return in request order
update_pc  input  1  redirect pulse from ALU (branch/jump/trap taken)
new_pc  input  32  redirect target, valid with update_pc
stall  input  1  decoder/pipeline stall; hold outputs
instr  output  32  instruction to decoder
pc  output  32  address of instr
instr_valid  output  1  instr/pc is a real fetched instruction (0 = bubble)
instr_misaligned  output  1  misaligned redirect flag (see Optional Feature)

Behaviour:
- Interface: clk is the single clock. reset_n is synchronous and active-low.
- Reset values:
  - instr=32'h00000013 (NOP), pc=RV32I_RESET_VECTOR, instr_valid=0, instr_misaligned=0, iread=0, iaddr=RV32I_RESET_VECTOR.
  - FIFO empty, outstanding=0, discard=0, fetch_addr=resp_addr=RV32I_RESET_VECTOR.
  - Reset mid-burst drops all in-flight responses. The memory is reset with the core.
- Request issue:
  - iread=1 when outstanding+fifo_count < RV32I_FETCH_DEPTH, or when a request is already pending.
  - iaddr=fetch_addr.
  - Accept = iread & ~iwaitrequest. On accept: fetch_addr+=4 (wraps at 2^32) and outstanding++.
  - While iwaitrequest=1, iread and iaddr are held unchanged. This holds across a redirect too: a request that is not yet accepted is never withdrawn.
- Responses:
  - On ireaddatavalid: outstanding--.
  - If discard>0: discard-- and the data is dropped.
  - Otherwise {ireaddata, resp_addr} is pushed to the FIFO and resp_addr+=4.
  - Accept and response in the same cycle leave outstanding unchanged.
  - The FIFO cannot overflow, by the issue rule.
- Output stage (registered):
  - If stall=1: instr, pc and instr_valid hold.
  - Else if FIFO non-empty: pop head into instr/pc with instr_valid=1.
  - Else: instr=NOP with instr_valid=0; pc holds.
  - A push to an empty FIFO is visible at the output no earlier than the following cycle, so minimum latency from ireaddatavalid to instr is 2 cycles.
- Redirect (update_pc=1, priority over stall and over pops):
  - FIFO flushed.
  - instr<=NOP, instr_valid<=0, pc<=new_pc.
  - fetch_addr<=resp_addr<=new_pc.
  - discard<=outstanding' (count after this cycle's response/accept), plus 1 if a request is pending but not yet accepted.
  - That held request: on acceptance it does not advance fetch_addr, and its response is discarded. Issue at new_pc starts the cycle after the held request is accepted; otherwise the cycle after update_pc.
  - update_pc in consecutive cycles: the last target wins, and the discard count accumulates correctly.
- Full/empty:
  - FIFO full with stall=1: iread stays 0.
  - FIFO empty with ~stall: a bubble each cycle.
  - Simultaneous push and pop at count RV32I_FETCH_DEPTH-1 is legal.

Optional Feature:
- Macro: RV32I_FETCH_MISALIGN_EN.
- Defined:
  - update_pc with new_pc[1:0]!=0 sets pc<=new_pc, instr<=NOP, instr_valid<=0 and instr_misaligned<=1.
  - Issue is halted (outstanding responses are still drained and discarded) until the next update_pc, which clears instr_misaligned.
- Not defined: new_pc[1:0] is forced to 2'b00 and instr_misaligned is tied 0.

Test Plan:
- Reset, zero-wait memory returning addr^32'hA5A50000 with 1-cycle latency:
  - iaddr sequence is 0,4,8,... once per cycle.
  - instr_valid is first 1 on cycle 3 after reset release, with pc=0 and instr=32'hA5A50000.
  - Thereafter one instruction per cycle.
- stall held 10 cycles with memory streaming: outstanding+fifo_count peaks at 4, iread=0 while full, instr/pc constant, no words lost or duplicated on release.
- iwaitrequest=1 for 3 cycles on iaddr=8: iread/iaddr held at 8 for all 3 cycles, accepted on the 4th, and pc sequence 0,4,8,12 is preserved.
- Memory latency 4, update_pc with new_pc=32'h100 while 3 reads outstanding: those 3 responses are dropped, the next instr_valid has pc=32'h100, and no instruction from the old path appears.
- update_pc while a request at 32'h20 is held by iwaitrequest: 32'h20 is accepted, then iaddr goes to the new target 32'h200; the 32'h20 response is discarded.
- With RV32I_FETCH_MISALIGN_EN, new_pc=32'h102: instr_misaligned=1, pc=32'h102, iread=0 until update_pc to 32'h200, which clears the flag and resumes fetch.

Source files
------------

// File: rtl/rv32i_fetch.sv
// rv32i_fetch: RV32I instruction fetch with prefetch FIFO and redirect flush; optional misaligned-redirect trap via RV32I_FETCH_MISALIGN_EN
module rv32i_fetch #(
  parameter logic [31:0] RV32I_RESET_VECTOR = 32'h00000000,
  parameter int          RV32I_FETCH_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] iaddr,
  output logic        iread,
  input  logic        iwaitrequest,
  input  logic [31:0] ireaddata,
  input  logic        ireaddatavalid,
  input  logic        update_pc,
  input  logic [31:0] new_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        instr_valid,
  output logic        instr_misaligned
);
  localparam int PW = $clog2(RV32I_FETCH_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h00000013;
  logic [31:0] fifo_data [RV32I_FETCH_DEPTH];
  logic [31:0] fifo_pc [RV32I_FETCH_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, outstanding, discard, outstanding_nx;
  logic [31:0] fetch_addr, resp_addr, held_addr, target;
  logic pend, stale, mis, room, accept, held, push, pop;
`ifdef RV32I_FETCH_MISALIGN_EN
  assign target = new_pc;
  always_ff @(posedge clk) begin
    if (!reset_n) mis <= 1'b0;
    else if (update_pc) mis <= |new_pc[1:0];
  end
`else
  logic unused_pc_bits;
  assign unused_pc_bits = ^new_pc[1:0];
  assign target = {new_pc[31:2], 2'b00};
  assign mis = 1'b0;
`endif
  assign instr_misaligned = mis;
  assign room = ({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(RV32I_FETCH_DEPTH);
  assign iread = reset_n & (pend | (room & ~mis));
  assign iaddr = pend ? held_addr : fetch_addr;
  assign accept = iread & ~iwaitrequest;
  assign held = iread & iwaitrequest;
  assign outstanding_nx = outstanding + CW'(accept) - CW'(ireaddatavalid);
  assign push = ireaddatavalid & (discard == '0) & ~update_pc;
  assign pop = ~update_pc & ~stall & (count != '0);
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= ireaddata;
      fifo_pc[wr_ptr] <= resp_addr;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_addr <= RV32I_RESET_VECTOR;
      resp_addr <= RV32I_RESET_VECTOR;
      held_addr <= RV32I_RESET_VECTOR;
      pend <= 1'b0;
      stale <= 1'b0;
      outstanding <= '0;
      discard <= '0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      instr <= NOP;
      pc <= RV32I_RESET_VECTOR;
      instr_valid <= 1'b0;
    end else begin
      pend <= held;
      held_addr <= iaddr;
      stale <= held & (stale | update_pc);
      outstanding <= outstanding_nx;
      if (update_pc) begin
        fetch_addr <= target;
        resp_addr <= target;
        discard <= outstanding_nx + CW'(held);
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        instr <= NOP;
        pc <= target;
        instr_valid <= 1'b0;
      end else begin
        if (accept && !stale) fetch_addr <= fetch_addr + 32'd4;
        if (ireaddatavalid && discard != '0) discard <= discard - CW'(1);
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
          resp_addr <= resp_addr + 32'd4;
        end
        count <= count + CW'(push) - CW'(pop);
        if (pop) begin
          instr <= fifo_data[rd_ptr];
          pc <= fifo_pc[rd_ptr];
          instr_valid <= 1'b1;
          rd_ptr <= rd_ptr + PW'(1);
        end else if (!stall) begin
          instr <= NOP;
          instr_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_rv32i_fetch.sv
// tb_rv32i_fetch: directed and randomized check of rv32i_fetch against a program-order fetch model
module tb_rv32i_fetch;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] KEY = 32'hA5A50000;
  typedef struct {
    int          due;
    logic [31:0] addr;
    logic        live;
  } rq_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] iaddr;
  logic iread;
  logic iwaitrequest = 1'b0;
  logic [31:0] ireaddata = '0;
  logic ireaddatavalid = 1'b0;
  logic update_pc = 1'b0;
  logic [31:0] new_pc = '0;
  logic stall = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic instr_valid;
  logic instr_misaligned;
  int errors = 0;
  int checks = 0;
  int cyc_n = 0;
  int lat = 1;
  int buffered = 0;
  int first;
  rq_t q[$];
  logic [31:0] exp_pc, next_fetch, prev_iaddr, m_instr, m_pc;
  logic prev_held, stale_held, m_valid, mis_m;
  rv32i_fetch dut (
    .clk(clk),
    .reset_n(reset_n),
    .iaddr(iaddr),
    .iread(iread),
    .iwaitrequest(iwaitrequest),
    .ireaddata(ireaddata),
    .ireaddatavalid(ireaddatavalid),
    .update_pc(update_pc),
    .new_pc(new_pc),
    .stall(stall),
    .instr(instr),
    .pc(pc),
    .instr_valid(instr_valid),
    .instr_misaligned(instr_misaligned)
  );
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    stall = 1'b0;
    update_pc = 1'b0;
    new_pc = '0;
    iwaitrequest = 1'b0;
    ireaddatavalid = 1'b0;
    ireaddata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_mis", 32'(instr_misaligned), 32'h0);
    chk("rst_iread", 32'(iread), 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    q.delete();
    buffered = 0;
    exp_pc = '0;
    next_fetch = '0;
    prev_iaddr = '0;
    prev_held = 1'b0;
    stale_held = 1'b0;
    mis_m = 1'b0;
    m_valid = 1'b0;
    m_instr = NOP;
    m_pc = '0;
    lat = 1;
    cyc_n = 0;
    reset_n = 1'b1;
  endtask
  task automatic cycle();
    logic [31:0] tgt;
    logic acc, held, dead_acc, push, pop, exp_rd;
    int sum, b0, due;
    sum = q.size() + buffered;
    b0 = buffered;
    push = 1'b0;
    ireaddatavalid = 1'b0;
    ireaddata = '0;
    if (q.size() != 0 && q[0].due <= cyc_n) begin
      ireaddatavalid = 1'b1;
      ireaddata = q[0].addr ^ KEY;
      push = q[0].live;
      q.delete(0);
    end
    tgt = new_pc;
`ifndef RV32I_FETCH_MISALIGN_EN
    tgt[1:0] = 2'b00;
`endif
    #1;
    exp_rd = prev_held | (sum < DEPTH && !mis_m);
    chk("iread", 32'(iread), 32'(exp_rd));
    chk("iaddr", iaddr, prev_held ? prev_iaddr : next_fetch);
    acc = iread && !iwaitrequest;
    held = iread && iwaitrequest;
    dead_acc = update_pc || (prev_held && stale_held);
    if (acc) begin
      due = cyc_n + lat;
      if (q.size() != 0 && q[$].due >= due) due = q[$].due + 1;
      q.push_back('{due: due, addr: iaddr, live: !dead_acc});
    end
    if (update_pc) begin
      foreach (q[i]) q[i].live = 1'b0;
      next_fetch = tgt;
    end else if (acc && !(prev_held && stale_held)) begin
      next_fetch = next_fetch + 32'd4;
    end
    stale_held = held && ((prev_held && stale_held) || update_pc);
    prev_held = held;
    prev_iaddr = iaddr;
    pop = !update_pc && !stall && b0 > 0;
    if (update_pc) begin
      buffered = 0;
      m_valid = 1'b0;
      m_instr = NOP;
      m_pc = tgt;
      exp_pc = tgt;
`ifdef RV32I_FETCH_MISALIGN_EN
      mis_m = new_pc[1:0] != 2'b00;
`endif
    end else begin
      buffered = b0 + int'(push) - int'(pop);
      if (pop) begin
        m_valid = 1'b1;
        m_pc = exp_pc;
        m_instr = exp_pc ^ KEY;
        exp_pc = exp_pc + 32'd4;
      end else if (!stall) begin
        m_valid = 1'b0;
        m_instr = NOP;
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("pc", pc, m_pc);
    chk("instr", instr, m_instr);
    chk("instr_misaligned", 32'(instr_misaligned), 32'(mis_m));
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  task automatic redirect(input logic [31:0] target);
    update_pc = 1'b1;
    new_pc = target;
    cycle();
    update_pc = 1'b0;
  endtask
  task automatic wait_valid(input string tag, input logic [31:0] exp);
    for (int i = 0; i < 40 && !instr_valid; i++) cycle();
    chk({tag, "_valid"}, 32'(instr_valid), 32'h1);
    chk({tag, "_pc"}, pc, exp);
  endtask
  initial begin
    do_reset();
    first = -1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (instr_valid && first < 0) begin
        first = cyc_n;
        chk("first_pc", pc, 32'h0);
        chk("first_instr", instr, 32'hA5A50000);
      end
    end
    chk("first_valid_cycle", first, 32'd3);
    stall = 1'b1;
    run(10);
    chk("stall_full_iread", 32'(iread), 32'h0);
    stall = 1'b0;
    run(10);
    do_reset();
    for (int i = 0; i < 20 && iaddr !== 32'h8; i++) cycle();
    chk("wait_addr", iaddr, 32'h8);
    iwaitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("wait_hold_addr", iaddr, 32'h8);
      chk("wait_hold_rd", 32'(iread), 32'h1);
    end
    iwaitrequest = 1'b0;
    cycle();
    chk("wait_accept_next", iaddr, 32'hC);
    run(8);
    do_reset();
    lat = 4;
    for (int i = 0; i < 10 && q.size() != 3; i++) cycle();
    chk("lat4_inflight", q.size(), 32'd3);
    redirect(32'h100);
    wait_valid("lat4_redirect", 32'h100);
    run(8);
    do_reset();
    for (int i = 0; i < 30 && iaddr !== 32'h20; i++) cycle();
    chk("held_addr_seen", iaddr, 32'h20);
    iwaitrequest = 1'b1;
    cycle();
    update_pc = 1'b1;
    new_pc = 32'h200;
    cycle();
    update_pc = 1'b0;
    chk("held_keep", iaddr, 32'h20);
    iwaitrequest = 1'b0;
    cycle();
    chk("held_then_target", iaddr, 32'h200);
    wait_valid("held_redirect", 32'h200);
    run(6);
    do_reset();
    run(4);
    redirect(32'h102);
`ifdef RV32I_FETCH_MISALIGN_EN
    chk("mis_flag", 32'(instr_misaligned), 32'h1);
    chk("mis_pc", pc, 32'h102);
    run(6);
    chk("mis_halt", 32'(iread), 32'h0);
    redirect(32'h200);
    chk("mis_clear", 32'(instr_misaligned), 32'h0);
    wait_valid("mis_resume", 32'h200);
`else
    chk("align_flag", 32'(instr_misaligned), 32'h0);
    chk("align_pc", pc, 32'h100);
    wait_valid("align_resume", 32'h100);
`endif
    run(4);
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      stall = $urandom_range(0, 9) < 3;
      iwaitrequest = $urandom_range(0, 9) < 2;
      update_pc = $urandom_range(0, 99) < 6;
      new_pc = ($urandom & 32'h00003FFC) | (($urandom_range(0, 9) == 0) ? 32'h2 : 32'h0);
      cycle();
    end
    stall = 1'b0;
    iwaitrequest = 1'b0;
    update_pc = 1'b0;
    redirect(32'h40);
    wait_valid("final_redirect", 32'h40);
    run(6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
